// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Purpose  : Shares the register file's single write port between the
//            writeback stage (priority) and a small FIFO of mult/div results.
//            A starvation counter forces a one-cycle WB stall when the FIFO
//            head has been denied MAX_WAIT cycles.
// Ports    : clk, reset (async, active-high)
//            wb_we/wb_addr/wb_data  in  : WB write request
//            wb_stall               out : WB not granted, WB holds request
//            md_valid/md_addr/md_data in: mult/div result
//            md_ready               out : FIFO can accept a result
//            rd_addr1/rd_addr2      in  : decode source registers
//            pending_hit1/2         out : source matches a buffered dest
//            rf_we/rf_waddr/rf_wdata out: register file write port
//            stall_cnt              out : saturating count of forced stalls
// Revision : 1.0  initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        pending_hit1,
  output logic        pending_hit2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;

  logic          empty;
  logic          force_head;
  logic          grant_fifo;
  logic          grant_wb;
  logic          push;
  logic          pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign empty      = (count == '0);
  assign force_head = (wait_cnt == WW'(MAX_WAIT)) && !empty;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Reset gates every grant so nothing reaches the port while reset is high,
  // even a WB request that does not depend on registered state.
  assign grant_fifo = !reset && !empty && (force_head || !wb_we);
  assign grant_wb   = !reset && wb_we && !force_head;
  assign wb_stall   = !reset && wb_we && force_head;

  // Full FIFO refuses a push even when the head pops in the same cycle.
  assign md_ready = !reset && (count < CW'(DEPTH));
  assign push     = md_valid && md_ready;
  assign pop      = grant_fifo;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (grant_fifo) begin
      rf_we    = (head_addr != 5'd0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end else if (grant_wb) begin
      rf_we    = (wb_addr != 5'd0);
      rf_waddr = wb_addr;
      rf_wdata = wb_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the
  // occupancy; pointer arithmetic wraps naturally since DEPTH is a power of 2.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset         = PW'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign match1[i]      = entry_valid[i] && (fifo_addr[i] == rd_addr1);
    assign match2[i]      = entry_valid[i] && (fifo_addr[i] == rd_addr2);
  end

  assign pending_hit1 = !reset && (rd_addr1 != 5'd0) && (|match1);
  assign pending_hit2 = !reset && (rd_addr2 != 5'd0) && (|match2);

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= md_addr;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      stall_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WW'(1);

      if (wb_stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Purpose  : Directed self-checking bench for rf_write_arbiter
//            (DEPTH=2, MAX_WAIT=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pending_hit1;
  logic        pending_hit2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_stall     (wb_stall),
    .md_valid     (md_valid),
    .md_addr      (md_addr),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .pending_hit1 (pending_hit1),
    .pending_hit2 (pending_hit2),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hA;
    md_valid = 1'b0; md_addr = 5'd0; md_data = 32'd0;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #2;
    check("rst_rf_we",     32'(rf_we), 32'd0);
    check("rst_wb_stall",  32'(wb_stall), 32'd0);
    check("rst_md_ready",  32'(md_ready), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick(); tick();
    reset = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    #1;
    check("post_rst_md_ready", 32'(md_ready), 32'd1);
    check("idle_rf_we",        32'(rf_we), 32'd0);

    // --- single md push with WB idle ---
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h1234; rd_addr1 = 5'd5;
    #1;
    check("push_not_visible", 32'(pending_hit1), 32'd0);
    check("push_cycle_rf_we", 32'(rf_we), 32'd0);
    tick();
    md_valid = 1'b0;
    #1;
    check("md_write_we",    32'(rf_we), 32'd1);
    check("md_write_addr",  32'(rf_waddr), 32'd5);
    check("md_write_data",  rf_wdata, 32'h1234);
    check("md_pending_hit", 32'(pending_hit1), 32'd1);
    tick();
    #1;
    check("after_pop_hit",  32'(pending_hit1), 32'd0);
    check("after_pop_we",   32'(rf_we), 32'd0);
    check("after_pop_addr", 32'(rf_waddr), 32'd0);

    // --- starvation: continuous WB with one buffered result ---
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hA;
    md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77; rd_addr2 = 5'd7;
    #1;
    check("wb_grant_addr",  32'(rf_waddr), 32'd3);
    check("wb_grant_stall", 32'(wb_stall), 32'd0);
    tick();
    md_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("denied_stall", 32'(wb_stall), 32'd0);
      check("denied_addr",  32'(rf_waddr), 32'd3);
      check("denied_hit2",  32'(pending_hit2), 32'd1);
      tick();
    end
    #1;
    check("force_stall",     32'(wb_stall), 32'd1);
    check("force_addr",      32'(rf_waddr), 32'd7);
    check("force_data",      rf_wdata, 32'h77);
    check("force_we",        32'(rf_we), 32'd1);
    check("force_cnt_early", 32'(stall_cnt), 32'd0);
    tick();
    #1;
    check("stall_cnt_one",   32'(stall_cnt), 32'd1);
    check("wb_after_force",  32'(wb_stall), 32'd0);
    check("wb_after_addr",   32'(rf_waddr), 32'd3);
    check("hit2_cleared",    32'(pending_hit2), 32'd0);

    // --- WB to r0: port granted but no write ---
    wb_addr = 5'd0;
    #1;
    check("wb_r0_we",    32'(rf_we), 32'd0);
    check("wb_r0_stall", 32'(wb_stall), 32'd0);
    wb_addr = 5'd3;

    // --- fill FIFO while WB busy ---
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h90;
    tick();
    md_addr = 5'd10; md_data = 32'hA0;
    #1;
    check("one_entry_ready", 32'(md_ready), 32'd1);
    tick();
    md_addr = 5'd11; md_data = 32'hB0;
    #1;
    check("full_ready", 32'(md_ready), 32'd0);
    tick();
    md_valid = 1'b0; rd_addr1 = 5'd11;
    #1;
    check("no_third_push", 32'(pending_hit1), 32'd0);
    check("still_full",    32'(md_ready), 32'd0);
    wb_we = 1'b0; rd_addr1 = 5'd10;
    #1;
    check("drain_head_addr", 32'(rf_waddr), 32'd9);
    check("drain_hit_10",    32'(pending_hit1), 32'd1);
    check("pop_full_ready",  32'(md_ready), 32'd0);
    tick();
    #1;
    check("ready_after_pop", 32'(md_ready), 32'd1);
    check("second_addr",     32'(rf_waddr), 32'd10);
    check("second_data",     rf_wdata, 32'hA0);
    tick();
    #1;
    check("drained_we", 32'(rf_we), 32'd0);

    // --- md result to r0 ---
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h5; rd_addr1 = 5'd0;
    tick();
    md_valid = 1'b0;
    #1;
    check("r0_pop_we",   32'(rf_we), 32'd0);
    check("r0_pop_addr", 32'(rf_waddr), 32'd0);
    check("r0_no_hit",   32'(pending_hit1), 32'd0);
    tick();
    #1;
    check("r0_idle_we", 32'(rf_we), 32'd0);

    // --- async reset with two buffered entries ---
    wb_we = 1'b1; wb_addr = 5'd3;
    md_valid = 1'b1; md_addr = 5'd12; md_data = 32'hC0;
    tick();
    md_addr = 5'd13; md_data = 32'hD0;
    tick();
    md_valid = 1'b0; rd_addr1 = 5'd12;
    #1;
    check("pre_rst_full", 32'(md_ready), 32'd0);
    check("pre_rst_hit",  32'(pending_hit1), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_we",        32'(rf_we), 32'd0);
    check("mid_rst_md_ready",  32'(md_ready), 32'd0);
    check("mid_rst_hit",       32'(pending_hit1), 32'd0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    reset = 1'b0; wb_we = 1'b0;
    #1;
    check("post_rst2_ready", 32'(md_ready), 32'd1);
    check("post_rst2_we",    32'(rf_we), 32'd0);
    check("post_rst2_hit",   32'(pending_hit1), 32'd0);
    tick();
    #1;
    check("no_stale_we", 32'(rf_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
